// File: rtl/bitblade_pkg.sv
// Shared types and helpers for the BitBlade weight/input sort-MUX sequencers.
// Holds bitwidth codes, the sequencer state encoding and the phases-per-word helper.
package bitblade_pkg;

    localparam logic [1:0] BW_8B = 2'b00;
    localparam logic [1:0] BW_4B = 2'b01;
    localparam logic [1:0] BW_2B = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } wseq_state_t;

    // 2'b11 is treated like 2b: one word yields four 8-bit sorted beats.
    function automatic logic [2:0] phases_per_word(input logic [1:0] bw);
        case (bw)
            BW_8B:   phases_per_word = 3'd1;
            BW_4B:   phases_per_word = 3'd2;
            default: phases_per_word = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/weight_mux_phase_ctr.sv
// MUX phase counter with last-phase decode; shared by the weight and input sequencers.
// clear wins over advance so a freshly captured word always starts at phase 0.
module weight_mux_phase_ctr
    import bitblade_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [1:0] bw,
    output logic [1:0] phase,
    output logic       last_phase
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 2'd0;
        end else if (clear) begin
            phase <= 2'd0;
        end else if (advance) begin
            phase <= phase + 2'd1;
        end
    end

    assign last_phase = ({1'b0, phase} == (phases_per_word(bw) - 3'd1));

endmodule

// File: rtl/weight_mux_sequencer.sv
// Weight-side sort-MUX sequencer: fetches buffer words, steps MUX phases, hands beats to the PE array.
// Optional build macro WSEQ_PERF_CNT_EN adds stall_cnt/beat_cnt performance counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds valid and its payload stable until that edge, and ready never depends on
// the consumer's own acceptance of the same beat.
module weight_mux_sequencer
    import bitblade_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        bitwidth,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              buf_valid,
    output logic              buf_ready,
    input  logic [DATA_W-1:0] buf_data,
    output logic [DATA_W-1:0] mux_buffer,
    output logic [1:0]        mux_state,
    output logic [1:0]        mux_bw,
    output logic              mux_reset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
`ifdef WSEQ_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       beat_cnt,
`endif
    output wseq_state_t       state_dbg
);

    wseq_state_t       state_q, state_d;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  words_left;
    logic [1:0]        bw_q;
    logic [1:0]        phase;
    logic              last_phase;

    logic start_acc, abort_act, beat_acc, last_acc, final_beat, word_take;

    assign start_acc  = (state_q == IDLE) && start;
    assign abort_act  = abort && (state_q != IDLE);
    assign beat_acc   = (state_q == ISSUE) && out_ready && !abort_act;
    assign last_acc   = beat_acc && last_phase;
    assign final_beat = last_acc && (words_left == CNT_W'(1));
    assign word_take  = buf_ready && buf_valid;

    weight_mux_phase_ctr u_phase_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (word_take || abort_act || final_beat),
        .advance    (beat_acc && !last_phase),
        .bw         (bw_q),
        .phase      (phase),
        .last_phase (last_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start) state_d = (num_words != '0) ? FETCH : DONE;
                FETCH: if (buf_valid) state_d = ISSUE;
                ISSUE: begin
                    if (final_beat)    state_d = DONE;
                    else if (last_acc) state_d = buf_valid ? ISSUE : FETCH;
                end
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The last-beat refill is the only ISSUE-state buf_ready: the held word is free exactly then.
    always_comb begin
        buf_ready = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        mux_reset = 1'b1;
        if (!abort_act) begin
            case (state_q)
                FETCH: buf_ready = 1'b1;
                ISSUE: begin
                    out_valid = 1'b1;
                    mux_reset = 1'b0;
                    buf_ready = last_acc && !final_beat;
                end
                DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q     <= '0;
            words_left <= '0;
            bw_q       <= BW_8B;
        end else begin
            if (start_acc && (num_words != '0)) begin
                bw_q       <= bitwidth;
                words_left <= num_words;
            end
            if (word_take) word_q <= buf_data;
            if (last_acc)  words_left <= words_left - CNT_W'(1);
        end
    end

    assign mux_buffer = word_q;
    assign mux_state  = phase;
    assign mux_bw     = bw_q;
    assign state_dbg  = state_q;

`ifdef WSEQ_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = (out_valid && !out_ready) ||
                       ((state_q == FETCH) && !abort_act && !buf_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (beat_acc && (beat_cnt != '1))   beat_cnt  <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_mux_sequencer.sv
// Self-checking bench for weight_mux_sequencer: directed tiles plus randomized tiles against a beat-queue model.
// Build with WSEQ_PERF_CNT_EN defined to also check the performance counters.
module tb_weight_mux_sequencer;
    import bitblade_pkg::*;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0, abort = 1'b0, buf_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]        bitwidth = 2'b00;
    logic [CNT_W-1:0]  num_words = '0;
    logic [DATA_W-1:0] buf_data = '0;
    logic              buf_ready, mux_reset, out_valid, busy, done;
    logic [DATA_W-1:0] mux_buffer;
    logic [1:0]        mux_state, mux_bw;
    wseq_state_t       state_dbg;
`ifdef WSEQ_PERF_CNT_EN
    logic [31:0]       stall_cnt, beat_cnt;
`endif

    weight_mux_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .bitwidth   (bitwidth),
        .num_words  (num_words),
        .buf_valid  (buf_valid),
        .buf_ready  (buf_ready),
        .buf_data   (buf_data),
        .mux_buffer (mux_buffer),
        .mux_state  (mux_state),
        .mux_bw     (mux_bw),
        .mux_reset  (mux_reset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
`ifdef WSEQ_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .beat_cnt   (beat_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];          // {word, phase, bw} per expected beat
    logic [31:0] words[$];          // words the buffer will offer this tile
    logic [31:0] preset[$];         // optional fixed words for the next tile
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc, done_cyc, done_cnt, first_beat_cyc, last_beat_cyc;
    int beats_seen, words_taken, wr_idx, bufrdy_cnt, ov_cnt, tile_n;
    logic [1:0]  tile_bw;
    logic        hold_pending = 1'b0;
    logic [35:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ppw(input logic [1:0] bw);
        return (bw == 2'b00) ? 1 : (bw == 2'b01) ? 2 : 4;
    endfunction

    // Called 1 time unit after the falling edge; predicts the handshakes of the next rising edge.
    task automatic monitor();
        logic [35:0] obs, e;
        obs = {mux_buffer, mux_state, mux_bw};
        if (buf_ready) bufrdy_cnt++;
        if (out_valid) ov_cnt++;
        chk("mux_reset", mux_reset, !out_valid);
        if (hold_pending && !abort) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", obs, prev_beat);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("beat", obs, e);
            end
            beats_seen++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        if (buf_valid && buf_ready) begin
            chk("buf_slot", words_taken < tile_n, 1'b1);
            for (int p = 0; p < ppw(tile_bw); p++)
                exp_q.push_back({words[wr_idx], 2'(p), tile_bw});
            wr_idx++;
            words_taken++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hold_pending = out_valid && !out_ready;
        prev_beat = obs;
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    // ---------------- driver ----------------
    task automatic begin_tile(input logic [1:0] bw, input int n);
        words.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++)
            words.push_back(preset.size() > 0 ? preset.pop_front() : $urandom);
        preset.delete();
        wr_idx = 0; words_taken = 0; beats_seen = 0; done_cnt = 0; done_cyc = -1;
        first_beat_cyc = -1; last_beat_cyc = -1; bufrdy_cnt = 0; ov_cnt = 0;
        tile_bw = bw; tile_n = n;
        start = 1'b1; bitwidth = bw; num_words = CNT_W'(n);
        buf_valid = 1'b0; out_ready = 1'b0;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        bitwidth = 2'($urandom);           // mid-tile changes must be ignored
        num_words = CNT_W'($urandom);
    endtask

    // mode 0: random ready; 1: three stall cycles; 2: ready toggles 1,0,1,0...
    task automatic run_tile(input logic [1:0] bw, input int n, input int vprob,
                            input int rprob, input int mode);
        bit full;
        full = (vprob == 100) && (rprob == 100) && (mode == 0);
        begin_tile(bw, n);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            buf_valid = ($urandom_range(0, 99) < vprob);
            buf_data  = (wr_idx < n) ? words[wr_idx] : $urandom;
            case (mode)
                1:       out_ready = !(k == 2 || k == 4 || k == 6);
                2:       out_ready = (k % 2 == 0);
                default: out_ready = ($urandom_range(0, 99) < rprob);
            endcase
            tick();
        end
        buf_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("busy_after_done", busy, 1'b0);
        chk("done_single", done, 1'b0);
        tick();
        chk("done_count", done_cnt, 1);
        chk("beats_total", beats_seen, n * ppw(bw));
        chk("words_total", words_taken, n);
        chk("queue_empty", exp_q.size(), 0);
        if (n > 0) chk("done_after_last", done_cyc, last_beat_cyc + 1);
        else begin
            chk("zero_done_lat", done_cyc, start_cyc + 1);
            chk("zero_buf_ready", bufrdy_cnt, 0);
            chk("zero_out_valid", ov_cnt, 0);
        end
        if (full && n > 0) begin
            chk("first_beat_lat", first_beat_cyc, start_cyc + 2);
            chk("no_bubble", last_beat_cyc - first_beat_cyc, n * ppw(bw) - 1);
        end
`ifdef WSEQ_PERF_CNT_EN
        chk("beat_cnt", beat_cnt, n * ppw(bw));
        if (mode == 1) chk("stall_cnt", stall_cnt, 3);
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mux_reset", mux_reset, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_buf_ready", buf_ready, 1'b0);
        chk("rst_mux_out", {mux_buffer, mux_state, mux_bw}, 36'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_tile(2'b00, 3, 100, 100, 0);
        preset.push_back(32'hA1B2C3D4);
        preset.push_back(32'h11223344);
        run_tile(2'b01, 2, 100, 100, 0);
        run_tile(2'b10, 1, 100, 100, 2);
        run_tile(2'b00, 0, 100, 100, 0);
        run_tile(2'b01, 4, 100, 100, 1);

        // abort in the second phase of word 2
        begin_tile(2'b01, 4);
        buf_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 50 && beats_seen < 3; k++) begin
            buf_data = (wr_idx < 4) ? words[wr_idx] : $urandom;
            tick();
        end
        chk("abort_reach", beats_seen, 3);
        abort = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_buf_ready", buf_ready, 1'b0);
        tick();
        abort = 1'b0; buf_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_idle", busy, 1'b0);
        chk("abort_mux_reset", mux_reset, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        chk("abort_no_done", done_cnt, 0);

        // async reset while waiting in FETCH
        begin_tile(2'b10, 2);
        tick();
        #1;
        chk("fetch_wait", buf_ready, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_buf_ready", buf_ready, 1'b0);
        chk("arst_mux_reset", mux_reset, 1'b1);
        chk("arst_mux_out", {mux_buffer, mux_state, mux_bw}, 36'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        hold_pending = 1'b0;
        tick();
        chk("arst_no_done", done_cnt, 0);

        run_tile(2'b01, 3, 100, 100, 0);
        for (int t = 0; t < 10; t++)
            run_tile(2'($urandom_range(0, 3)), $urandom_range(1, 6),
                     $urandom_range(30, 100), $urandom_range(30, 100), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
